// File: rtl/spi_rx.sv
// SPI 8-bit receiver: synchronises the SPI pin bundle, deserialises MSB-first
// frames with their D/C flag, and queues them in a small FIFO read through dout/rd.
module spi_rx #(
    parameter int DEPTH = 4
) (
    input  logic        clk_125mhz,
    input  logic        reset,
    input  logic [7:0]  spi_in,
    input  logic        rd,
    output logic [31:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // pmoden, vccen, res_ and the fixed-zero bit carry nothing for the receiver
    logic unused_pins;
    assign unused_pins = ^{spi_in[7:5], spi_in[2]};

    logic [2:0] cs_sr;
    logic [2:0] sck_sr;
    logic [1:0] sdo_sr;
    logic [1:0] dc_sr;

    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            cs_sr  <= 3'b111;
            sck_sr <= 3'b111;
            sdo_sr <= 2'b00;
            dc_sr  <= 2'b00;
        end else begin
            cs_sr  <= {cs_sr[1:0], spi_in[0]};
            sck_sr <= {sck_sr[1:0], spi_in[3]};
            sdo_sr <= {sdo_sr[0], spi_in[1]};
            dc_sr  <= {dc_sr[0], spi_in[4]};
        end
    end

    logic cs_now, cs_fall, cs_rise, sck_rise, sdo_now, dc_now;
    assign cs_now   = cs_sr[1];
    assign cs_fall  = cs_sr[2] & ~cs_sr[1];
    assign cs_rise  = ~cs_sr[2] & cs_sr[1];
    assign sck_rise = ~sck_sr[2] & sck_sr[1];
    assign sdo_now  = sdo_sr[1];
    assign dc_now   = dc_sr[1];

    state_t     state;
    logic [1:0] warm_cnt;
    logic       armed;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       dc_lat;
    logic       bad;
    logic       push;
    logic [8:0] push_word;
    logic       err_set;

    // armed only after the sync chain reflects the pin and cs_ has been seen high,
    // so a cs_ held low through reset release never starts a frame
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            warm_cnt  <= 2'd0;
            armed     <= 1'b0;
            bitcnt    <= 3'd0;
            shreg     <= 8'h00;
            dc_lat    <= 1'b0;
            bad       <= 1'b0;
            push      <= 1'b0;
            push_word <= 9'h000;
            err_set   <= 1'b0;
        end else begin
            push    <= 1'b0;
            err_set <= 1'b0;
            if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
            if (warm_cnt == 2'd3 && cs_now) armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        dc_lat <= dc_now;
                        bitcnt <= 3'd0;
                        shreg  <= 8'h00;
                        bad    <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        err_set <= 1'b1;
                        state   <= IDLE;
                    end else if (sck_rise && !cs_now) begin
                        shreg  <= {shreg[6:0], sdo_now};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= DONE;
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        if (bad) begin
                            err_set <= 1'b1;
                        end else begin
                            push      <= 1'b1;
                            push_word <= {dc_lat, shreg};
                        end
                        state <= IDLE;
                    end else if (sck_rise && !cs_now) begin
                        bad <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [AW:0]   count, count_n;
    logic          ovf, ovf_n, err, err_n;
    logic          do_pop, do_push;
    logic [8:0]    head_n;

    // a pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        do_pop   = rd && (count != '0);
        do_push  = push && ((count != FULL_CNT) || do_pop);
        rd_ptr_n = do_pop ? rd_ptr + PTR_ONE : rd_ptr;
        count_n  = count;
        if (do_push && !do_pop) count_n = count + CNT_ONE;
        if (do_pop && !do_push) count_n = count - CNT_ONE;
        ovf_n    = (push && !do_push) || (ovf && !rd);
        err_n    = err_set || (err && !rd);
        head_n   = (do_push && rd_ptr_n == wr_ptr) ? push_word : mem[rd_ptr_n];
        if (count_n == '0) head_n = 9'h000;
    end

    always_ff @(posedge clk_125mhz) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            dout   <= 32'h0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            ovf    <= ovf_n;
            err    <= err_n;
            dout   <= {15'h0, err_n, 4'(count_n), ovf_n, (count_n == FULL_CNT),
                       (count_n != '0), head_n};
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: drives SPI frames on the pin bundle and checks dout
// against hand-computed words.
module tb_spi_rx;

    localparam int HALF = 50;

    logic        clk_125mhz = 1'b0;
    logic        reset;
    logic        rd;
    logic [31:0] dout;
    logic        cs_pin, sdo_pin, sck_pin, dc_pin;
    logic [7:0]  spi_in;

    int compared   = 0;
    int mismatched = 0;

    assign spi_in = {1'b0, 1'b0, 1'b1, dc_pin, sck_pin, 1'b0, sdo_pin, cs_pin};

    spi_rx #(.DEPTH(4)) dut (
        .clk_125mhz (clk_125mhz),
        .reset      (reset),
        .spi_in     (spi_in),
        .rd         (rd),
        .dout       (dout)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_125mhz);
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        compared++;
        assert (dout === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, dout, exp);
        end
    endtask

    task automatic start_frame(input logic dc);
        dc_pin = dc;
        wait_cyc(HALF);
        cs_pin = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic clock_bits(input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < n; i++) begin
            sck_pin = 1'b0;
            sdo_pin = (i < 8) ? v[7 - i] : 1'b0;
            wait_cyc(HALF);
            sck_pin = 1'b1;
            wait_cyc(HALF);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic dc, input int n);
        start_frame(dc);
        clock_bits(b, n);
        cs_pin = 1'b1;
    endtask

    task automatic pop;
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd = 1'b0;
        cs_pin = 1'b1; sdo_pin = 1'b0; sck_pin = 1'b1; dc_pin = 1'b0;
        wait_cyc(5);
        check("reset", 32'h0);
        reset = 1'b0;
        wait_cyc(5);
        check("after_release", 32'h0);

        // single frame, dc=1, 0xA5
        send_frame(8'hA5, 1'b1, 8);
        wait_cyc(4);
        check("a5_push", 32'h0000_13A5);
        pop;
        check("a5_pop", 32'h0);

        // five frames, fifth overflows
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 8);
            wait_cyc(4);
            if (i == 1) check("f1", 32'h0000_1201);
            if (i == 4) check("f4_full", 32'h0000_4601);
            if (i == 5) check("f5_ovf", 32'h0000_4E01);
        end
        pop;
        check("rd1_ovf_clr", 32'h0000_3202);
        pop;
        check("rd2", 32'h0000_2203);
        pop;
        check("rd3", 32'h0000_1204);
        pop;
        check("rd4_empty", 32'h0);

        // short frame then a good one
        send_frame(8'hFF, 1'b0, 5);
        wait_cyc(4);
        check("short_err", 32'h0001_0000);
        pop;
        check("short_clr", 32'h0);
        send_frame(8'h3C, 1'b0, 8);
        wait_cyc(4);
        check("after_short", 32'h0000_123C);
        pop;
        check("after_short_pop", 32'h0);

        // long frame
        send_frame(8'h55, 1'b1, 9);
        wait_cyc(4);
        check("long_err", 32'h0001_0000);
        pop;
        check("long_clr", 32'h0);

        // full FIFO, pop coincides with push of 0x7E
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 8);
            wait_cyc(4);
        end
        check("fill", 32'h0000_4610);
        send_frame(8'h7E, 1'b0, 8);
        wait_cyc(3);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
        check("full_rd_push", 32'h0000_4611);
        wait_cyc(4);
        check("full_rd_push_settled", 32'h0000_4611);
        pop;
        check("drain_12", 32'h0000_3212);
        pop;
        check("drain_13", 32'h0000_2213);
        pop;
        check("drain_7e", 32'h0000_127E);
        pop;
        check("drain_empty", 32'h0);

        // reset mid-frame with cs_ held low through release
        start_frame(1'b0);
        clock_bits(8'hF0, 4);
        reset = 1'b1;
        wait_cyc(3);
        check("mid_reset", 32'h0);
        reset = 1'b0;
        wait_cyc(20);
        check("mid_release", 32'h0);
        cs_pin = 1'b1;
        wait_cyc(10);
        check("mid_cs_rise", 32'h0);
        send_frame(8'h81, 1'b1, 8);
        wait_cyc(4);
        check("after_reset_frame", 32'h0000_1381);
        pop;
        check("after_reset_pop", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
